// File: rtl/x86_regfile_pkg.sv
// Shared definitions for the 8-bit general register file (AX,BX,CX,DX):
// data/address widths, number of implemented registers, default write-back
// FIFO depth, and the pending-write entry type used by write-back and decode.
package x86_regfile_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 4;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/x86_regfile_writeback_if.sv
// Result-write request stream from the execution units into the write-back block.
//   in_valid : producer has a write request
//   in_ready : write-back accepts the request this cycle
//   in_addr  : destination register
//   in_data  : value to write
// master = producer (execution unit), slave = write-back controller.
interface x86_regfile_writeback_if;
    import x86_regfile_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_addr, output in_data, input in_ready);
    modport slave  (input in_valid, input in_addr, input in_data, output in_ready);
endinterface

// File: rtl/x86_regfile_writeback_wb_fifo.sv
// wb_fifo: generic in-order FIFO of wb_entry_t.
//   clk, rst   : clock, asynchronous active-high reset
//   push/pop   : enqueue wr_entry / dequeue head (caller guarantees not full / not empty)
//   flush      : discard everything, overrides push/pop
//   head       : oldest entry
//   entries    : contents in age order, entries[0] = oldest
//   valid      : valid[i] set when entries[i] holds a pending write
//   full/empty : derived from the extra pointer MSB
//   count      : occupancy
module wb_fifo
    import x86_regfile_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  wb_entry_t                  wr_entry,
    output wb_entry_t                  head,
    output wb_entry_t                  entries [DEPTH],
    output logic [DEPTH-1:0]           valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t   mem_q [DEPTH];
    wb_entry_t   mem_d [DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[PW-1:0]] = wr_entry;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Same index bits, different wrap bit means the writer has lapped the reader.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign count = CNT_W'(wr_ptr_q - rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[PW-1:0]];

    // Present storage rotated so index 0 is the oldest; the PW-bit add wraps naturally.
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign entries[g] = mem_q[rd_ptr_q[PW-1:0] + PW'(g)];
        assign valid[g]   = CNT_W'(g) < count;
    end
endmodule

// File: rtl/x86_regfile_writeback.sv
// x86_regfile_writeback: write-side controller for the general register file.
// Buffers result writes in an in-order FIFO, drains one per cycle onto the
// register-file write port, and forwards pending values to operand read logic.
//   clk, rst         : clock, asynchronous active-high reset
//   in_if (slave)    : valid/ready write request stream
//   flush            : synchronous discard of all pending writes
//   wb_stall         : hold, no new write issued
//   rf_write_*       : register-file write port (enable high one cycle per write)
//   fwd_addr/hit/data: youngest pending value for fwd_addr
//   count            : FIFO occupancy (staged write excluded)
//   err_addr         : one-cycle pulse when an illegal address was dropped
module x86_regfile_writeback
    import x86_regfile_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    x86_regfile_writeback_if.slave     in_if,
    input  logic                       flush,
    input  logic                       wb_stall,
    output logic                       rf_write_enable,
    output logic [ADDR_W-1:0]          rf_write_addr,
    output logic [DATA_W-1:0]          rf_write_data,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_addr
);
    wb_entry_t        head;
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             full;
    logic             empty;
    logic             accept;
    logic             legal;
    logic             push;
    logic             pop;

    wb_entry_t staged_q, staged_d;
    logic      we_q, we_d;
    logic      err_q, err_d;

    // Illegal addresses still complete the handshake; they are just not enqueued.
    assign in_if.in_ready = !full && !flush;
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign legal          = in_if.in_addr < ADDR_W'(NUM_REGS);
    assign push           = accept && legal;
    assign pop            = !empty && !wb_stall && !flush;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_entry ('{addr: in_if.in_addr, data: in_if.in_data}),
        .head     (head),
        .entries  (entries),
        .valid    (valid),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_comb begin
        staged_d = staged_q;
        we_d     = pop;
        err_d    = accept && !legal;
        if (pop) staged_d = head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staged_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            staged_q <= staged_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_write_addr   = staged_q.addr;
    assign rf_write_data   = staged_q.data;
    assign err_addr        = err_q;

    // Oldest to youngest: staged write first, then FIFO head to tail, so the
    // last match found is the youngest pending value.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (we_q && staged_q.addr == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = staged_q.data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && entries[i].addr == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[i].data;
            end
        end
    end
endmodule

// File: tb/tb_x86_regfile_writeback.sv
// Self-checking bench for x86_regfile_writeback: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_x86_regfile_writeback;
    import x86_regfile_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    x86_regfile_writeback_if bus ();

    logic              flush    = 1'b0;
    logic              wb_stall = 1'b0;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic [ADDR_W-1:0] fwd_addr = '0;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [2:0]        count;
    logic              err_addr;

    x86_regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_if           (bus),
        .flush           (flush),
        .wb_stall        (wb_stall),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .fwd_addr        (fwd_addr),
        .fwd_hit         (fwd_hit),
        .fwd_data        (fwd_data),
        .count           (count),
        .err_addr        (err_addr)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: mq = writes waiting in the buffer (oldest first),
    // stg = write on the register-file port this cycle, wq = scoreboard of
    // writes the register file must still see, in order.
    wb_entry_t   mq[$];
    wb_entry_t   wq[$];
    wb_entry_t   stg;
    logic        stg_v   = 1'b0;
    logic        err_exp = 1'b0;
    logic [7:0]  rf_model [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void fwd_ref(input logic [2:0] a, output logic h, output logic [7:0] d);
        h = 1'b0;
        d = 8'h00;
        if (stg_v && stg.addr == a) begin
            h = 1'b1;
            d = stg.data;
        end
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].addr == a) begin
                h = 1'b1;
                d = mq[i].data;
            end
        end
    endfunction

    task automatic step(input logic v, input logic [2:0] a, input logic [7:0] d,
                        input logic fl, input logic st, input logic [2:0] fa);
        logic       h;
        logic [7:0] fd;
        logic       acc;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
        flush        = fl;
        wb_stall     = st;
        fwd_addr     = fa;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'((mq.size() < DEPTH) && !fl));
        chk("count", 32'(count), 32'(mq.size()));
        chk("wr_enable", 32'(rf_write_enable), 32'(stg_v));
        chk("err_addr", 32'(err_addr), 32'(err_exp));
        fwd_ref(fa, h, fd);
        chk("fwd_hit", 32'(fwd_hit), 32'(h));
        chk("fwd_data", 32'(fwd_data), 32'(fd));
        @(posedge clk);
        if (fl) begin
            mq.delete();
            stg_v   = 1'b0;
            err_exp = 1'b0;
        end else begin
            acc = v && (mq.size() < DEPTH);
            if (mq.size() > 0 && !st) begin
                stg   = mq.pop_front();
                stg_v = 1'b1;
                wq.push_back(stg);
            end else begin
                stg_v = 1'b0;
            end
            err_exp = acc && (a >= 3'(NUM_REGS));
            if (acc && a < 3'(NUM_REGS)) mq.push_back('{addr: a, data: d});
        end
    endtask

    task automatic idle(input logic st);
        step(1'b0, 3'd0, 8'h00, 1'b0, st, 3'd0);
    endtask

    // Monitor: every write the DUT presents must be the next scoreboard entry.
    always @(negedge clk) begin
        wb_entry_t e;
        if (!rst && rf_write_enable) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected none", rf_write_addr, rf_write_data);
            end else begin
                e = wq.pop_front();
                chk("write_addr", 32'(rf_write_addr), 32'(e.addr));
                chk("write_data", 32'(rf_write_data), 32'(e.data));
                rf_model[rf_write_addr] = rf_write_data;
            end
        end
    end

    initial begin
        logic       v;
        logic [2:0] a;
        logic       fl;
        logic       st;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        for (int i = 0; i < 8; i++) rf_model[i] = 8'h00;
        #1;
        chk("rst_wr_enable", 32'(rf_write_enable), 32'd0);
        chk("rst_wr_addr", 32'(rf_write_addr), 32'd0);
        chk("rst_wr_data", 32'(rf_write_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single write, two-cycle latency to the register file.
        step(1'b1, 3'd1, 8'h5A, 1'b0, 1'b0, 3'd0);
        idle(1'b0);
        #1;
        chk("t1_enable", 32'(rf_write_enable), 32'd1);
        chk("t1_addr", 32'(rf_write_addr), 32'd1);
        chk("t1_data", 32'(rf_write_data), 32'h5A);
        chk("t1_count", 32'(count), 32'd0);
        idle(1'b0);
        chk("t1_bx", 32'(rf_model[1]), 32'h5A);

        // Fill under stall, then drain in order one per cycle.
        for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 8'(10 + i), 1'b0, 1'b1, 3'd0);
        #1;
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_ready_full", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            #1;
            chk("t2_enable", 32'(rf_write_enable), 32'd1);
            chk("t2_addr", 32'(rf_write_addr), 32'(i));
            chk("t2_data", 32'(rf_write_data), 32'(10 + i));
        end
        idle(1'b0);

        // Forwarding: youngest same-address write wins.
        step(1'b1, 3'd2, 8'h11, 1'b0, 1'b1, 3'd0);
        step(1'b1, 3'd2, 8'h22, 1'b0, 1'b1, 3'd0);
        step(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd2);
        #1;
        chk("t3_hit", 32'(fwd_hit), 32'd1);
        chk("t3_data", 32'(fwd_data), 32'h22);
        step(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd3);
        #1;
        chk("t3_miss", 32'(fwd_hit), 32'd0);
        chk("t3_miss_data", 32'(fwd_data), 32'd0);
        repeat (4) idle(1'b0);

        // Illegal address: accepted, dropped, one-cycle error pulse.
        step(1'b1, 3'd5, 8'hFF, 1'b0, 1'b0, 3'd0);
        #1;
        chk("t4_err", 32'(err_addr), 32'd1);
        chk("t4_count", 32'(count), 32'd0);
        idle(1'b0);
        #1;
        chk("t4_err_clear", 32'(err_addr), 32'd0);
        chk("t4_no_write", 32'(rf_write_enable), 32'd0);

        // Flush with three pending; a request during flush is refused.
        for (int i = 0; i < 3; i++) step(1'b1, 3'(i), 8'(8'h30 + i), 1'b0, 1'b1, 3'd0);
        step(1'b1, 3'd1, 8'h77, 1'b1, 1'b0, 3'd0);
        #1;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_enable", 32'(rf_write_enable), 32'd0);
        repeat (2) begin
            idle(1'b0);
            #1;
            chk("t5_no_write", 32'(rf_write_enable), 32'd0);
        end

        // Asynchronous reset mid-drain.
        for (int i = 0; i < 3; i++) step(1'b1, 3'(i), 8'(8'h40 + i), 1'b0, 1'b1, 3'd0);
        idle(1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_enable", 32'(rf_write_enable), 32'd0);
        chk("t5_rst_addr", 32'(rf_write_addr), 32'd0);
        chk("t5_rst_data", 32'(rf_write_data), 32'd0);
        chk("t5_rst_count", 32'(count), 32'd0);
        chk("t5_rst_err", 32'(err_addr), 32'd0);
        mq.delete();
        wq.delete();
        stg_v   = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Full FIFO: pop and a new request in the same cycle, push refused.
        for (int i = 0; i < 4; i++) step(1'b1, 3'(3 - i), 8'(8'h50 + i), 1'b0, 1'b1, 3'd0);
        step(1'b1, 3'd3, 8'hAA, 1'b0, 1'b0, 3'd0);
        #1;
        chk("t6_count", 32'(count), 32'd3);
        repeat (4) idle(1'b0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            v  = $urandom_range(0, 99) < 60;
            a  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            fl = $urandom_range(0, 49) == 0;
            st = $urandom_range(0, 99) < 30;
            step(v, a, 8'($urandom), fl, st, 3'($urandom_range(0, 7)));
        end
        repeat (8) idle(1'b0);
        chk("drain_empty", 32'(wq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
